// File: rtl/sja_bus_pkg.sv
// Shared types and default bus timing for the SJA1000 parallel bus master.
package sja_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE,
        S_AHOLD,
        S_SETUP,
        S_WDATA,
        S_STROBE,
        S_RECOV,
        S_DONE
    } state_t;

    // Default phase lengths in clk cycles.
    localparam int T_ALE_DEF = 2;
    localparam int T_AH_DEF  = 1;
    localparam int T_SU_DEF  = 1;
    localparam int T_WR_DEF  = 2;
    localparam int T_RD_DEF  = 3;
    localparam int T_REC_DEF = 1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sja_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module sja_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/sja_bus_master.sv
// Burst master for the SJA1000 multiplexed address/data bus (Intel mode).
module sja_bus_master
    import sja_bus_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int LW    = 4,
    parameter int T_ALE = T_ALE_DEF,
    parameter int T_AH  = T_AH_DEF,
    parameter int T_SU  = T_SU_DEF,
    parameter int T_WR  = T_WR_DEF,
    parameter int T_RD  = T_RD_DEF,
    parameter int T_REC = T_REC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] wdata,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          done,
    output logic          busy,
    output logic [DW-1:0] ad_o,
    input  logic [DW-1:0] ad_i,
    output logic          ad_oe,
    output logic          ale,
    output logic          cs_n,
    output logic          rd_n,
    output logic          wr_n
);

    localparam int TMAX = imax(imax(imax(T_ALE, T_AH), imax(T_SU, T_WR)), imax(T_RD, T_REC));
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, ns;
    logic          wr, nwr;
    logic [LW-1:0] beats, nbeats;
    logic [AW-1:0] addr, naddr;
    logic          tc, load;
    logic [TW-1:0] load_val;
    logic          last_rd;

    sja_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    // Next-state decode; beats/address advance only on the RECOV->ALE hop.
    always_comb begin
        ns     = state;
        nwr    = wr;
        nbeats = beats;
        naddr  = addr;
        case (state)
            S_IDLE:   if (cmd_valid) begin
                          ns     = S_ALE;
                          nwr    = cmd_write;
                          nbeats = cmd_len;
                          naddr  = cmd_addr;
                      end
            S_ALE:    if (tc) ns = S_AHOLD;
            S_AHOLD:  if (tc) ns = S_SETUP;
            S_SETUP:  if (tc) ns = wr ? S_WDATA : S_STROBE;
            S_WDATA:  if (wdata_valid) ns = S_STROBE;
            S_STROBE: if (tc) ns = S_RECOV;
            S_RECOV:  if (tc) begin
                          if (beats == '0) begin
                              ns = S_DONE;
                          end else begin
                              ns     = S_ALE;
                              nbeats = beats - 1'b1;
                              naddr  = addr + 1'b1;
                          end
                      end
            S_DONE:   ns = S_IDLE;
            default:  ns = S_IDLE;
        endcase
    end

    // Phase length of the state being entered; the timer reloads on every state change.
    always_comb begin
        case (ns)
            S_ALE:    load_val = TW'(T_ALE - 1);
            S_AHOLD:  load_val = TW'(T_AH - 1);
            S_SETUP:  load_val = TW'(T_SU - 1);
            S_STROBE: load_val = nwr ? TW'(T_WR - 1) : TW'(T_RD - 1);
            S_RECOV:  load_val = TW'(T_REC - 1);
            default:  load_val = '0;
        endcase
    end

    assign load    = (ns != state);
    assign last_rd = (state == S_STROBE) && tc && !wr;

    // FSM state plus every bus/handshake output, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr          <= 1'b0;
            beats       <= '0;
            addr        <= '0;
            ale         <= 1'b0;
            cs_n        <= 1'b1;
            rd_n        <= 1'b1;
            wr_n        <= 1'b1;
            ad_oe       <= 1'b0;
            ad_o        <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wdata_ready <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            state       <= ns;
            wr          <= nwr;
            beats       <= nbeats;
            addr        <= naddr;
            ale         <= (ns == S_ALE);
            cs_n        <= !(ns inside {S_SETUP, S_WDATA, S_STROBE});
            rd_n        <= !((ns == S_STROBE) && !nwr);
            wr_n        <= !((ns == S_STROBE) && nwr);
            // Reads release the bus from SETUP onward so the chip can drive it.
            ad_oe       <= (ns inside {S_ALE, S_AHOLD}) ||
                           (nwr && (ns inside {S_SETUP, S_WDATA, S_STROBE}));
            wdata_ready <= (ns == S_WDATA);
            done        <= (ns == S_DONE);
            busy        <= (ns != S_IDLE);
            cmd_ready   <= (ns == S_IDLE);
            if ((ns == S_ALE) && (state != S_ALE))
                ad_o <= DW'(naddr);
            else if ((state == S_WDATA) && wdata_valid)
                ad_o <= wdata;
            rdata_valid <= last_rd;
            if (last_rd)
                rdata <= ad_i;
        end
    end

endmodule

// File: doc/sja_bus_master.md
SJA_BUS_MASTER -- requirements
Module: sja_bus_master

Interface
REQ-001 SHALL have parameter DW, default 8, data width of the multiplexed AD bus.
REQ-002 SHALL have parameter AW, default 8, address width (AW <= DW).
REQ-003 SHALL have parameter LW, default 4, burst-length field width (max 2^LW beats).
REQ-004 SHALL have parameters T_ALE 2, T_AH 1, T_SU 1, T_WR 2, T_RD 3, T_REC 1: phase lengths in clk cycles, each >= 1.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  sole clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-010 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-011 cmd_addr  in  AW  first beat address.
REQ-012 cmd_len  in  LW  beats minus one.
REQ-013 wdata / wdata_valid / wdata_ready  in DW / in 1 / out 1  per-beat write data handshake.
REQ-014 rdata / rdata_valid  out DW / out 1  per-beat read data; no backpressure.
REQ-015 done  out  1  one-cycle pulse at burst end.
REQ-016 busy  out  1  high from acceptance until done inclusive.
REQ-017 ad_o / ad_i / ad_oe  out DW / in DW / out 1  AD bus split; the tri-state buffer lives at the pad.
REQ-018 ale, cs_n, rd_n, wr_n  out  1 each  SJA1000 bus strobes.

Function
REQ-019 cmd_ready SHALL be 1 only in IDLE; acceptance latches cmd_write, cmd_addr and cmd_len.
REQ-020 States SHALL be IDLE, ALE, AHOLD, SETUP, WDATA (write only), STROBE, RECOV, DONE.
REQ-021 ALE: ale=1, ad_oe=1, ad_o=current address zero-extended; lasts T_ALE cycles.
REQ-022 AHOLD: ale=0, address still driven; lasts T_AH cycles.
REQ-023 SETUP: cs_n=0; on a read, ad_oe=0 from the first SETUP cycle; lasts T_SU cycles.
REQ-024 WDATA: wdata_ready=1; on wdata_valid, register ad_o=wdata and move to STROBE; otherwise stall indefinitely with cs_n held low.
REQ-025 STROBE: wr_n=0 (write) or rd_n=0 (read), lasting T_WR or T_RD cycles respectively.
REQ-026 On a read, ad_i SHALL be registered into rdata on the last STROBE cycle; rdata_valid pulses one cycle in the next cycle, coincident with rd_n=1.
REQ-027 RECOV: cs_n=1, rd_n=wr_n=1, ad_oe=0; lasts T_REC cycles.
REQ-028 After RECOV, if beats remain, the FSM SHALL go to ALE with address+1, wrapping modulo 2^AW; otherwise it SHALL go to DONE.
REQ-029 DONE: done=1 for one cycle, then IDLE; a command offered during DONE SHALL wait until IDLE.
REQ-030 rd_n and wr_n SHALL never be low simultaneously; ale SHALL never be high while cs_n=0.
REQ-031 Phase timing SHALL use one down-counter sized $clog2(max T + 1), loaded on each state entry.

Reset
REQ-032 rst SHALL force IDLE with ale=0, cs_n=rd_n=wr_n=1, ad_oe=0, ad_o=0, rdata=0, and all valid/ready/done/busy outputs low except cmd_ready.
REQ-033 cmd_ready SHALL be 1 in the cycle after reset is released.
REQ-034 A reset mid-burst SHALL abort the burst with no done pulse and no further rdata_valid.

Structure
REQ-035 Package sja_bus_pkg SHALL hold the state enum and the default timing constants.
REQ-036 Sub-module sja_phase_timer SHALL implement the loadable down-counter with a terminal-count flag.

Verification (acceptance = cycle 0, all timings at defaults)
REQ-037 Single write: addr 0x12, wdata 0x5A already valid -> ale high cycles 1-2, wr_n low cycles 6-7 with ad_o=0x5A, done in cycle 9.
REQ-038 Single read: addr 0x03, ad_i=0xC4 -> ad_oe=0 from cycle 4, rd_n low cycles 5-7, rdata=0xC4 with rdata_valid in cycle 8, done in cycle 9.
REQ-039 Write burst: cmd_len=3 at addr 0xFE, wdata_valid withheld 5 cycles on beat 2 -> addresses FE,FF,00,01; cs_n stays low during the stall; exactly 4 wr_n pulses.
REQ-040 Reset asserted during the STROBE of beat 1 of a 4-beat read -> all strobes idle next cycle, no done pulse, cmd_ready=1 after release.
REQ-041 Back-to-back commands: cmd_valid held through DONE -> second command accepted in the first IDLE cycle, busy low for exactly that one cycle.
REQ-042 Assertion bench: REQ-030 invariants hold across randomised bursts with T_RD=1 and T_REC=1.
